// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 run controller.
package lc3_pkg;

    typedef logic [15:0] word_t;

    localparam word_t HALT_OP = 16'hF025;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RUN,
        S_PAUSED,
        S_HALTED,
        S_TIMEOUT
    } state_t;

endpackage

// File: rtl/lc3_bp_match.sv
// BP_NUM-way PC breakpoint comparator; bit i set when channel i is enabled and its address equals pc.
module lc3_bp_match
    import lc3_pkg::*;
#(
    parameter int BP_NUM = 2
) (
    input  logic [15:0]          pc,
    input  logic [16*BP_NUM-1:0] bp_addr,
    input  logic [BP_NUM-1:0]    bp_en,
    output logic [BP_NUM-1:0]    hit
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < BP_NUM; i++) begin
            hit[i] = bp_en[i] && (word_t'(pc) == word_t'(bp_addr[16*i +: 16]));
        end
    end

endmodule

// File: rtl/lc3_run_ctrl.sv
// Run sequencer for an LC-3 core: reset hold, run with cycle budget, HALT detect, optional
// PC breakpoints (enabled by defining LC3_RUN_CTRL_BP_EN).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | core held in reset, waiting for start
// RST_HOLD   | core reset held for RST_CYCLES cycles after leaving IDLE
// RUN        | core enabled, counters advancing, budget decrementing
// PAUSED     | stopped on a breakpoint, waiting for resume
// HALTED     | run ended by TRAP x25, waiting for start to drop
// TIMEOUT    | run ended by budget expiry, waiting for start to drop
module lc3_run_ctrl
    import lc3_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 500000,
    parameter int CNT_W      = 32,
    parameter int BP_NUM     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 instr_valid,
    input  logic [15:0]          instr,
    input  logic [15:0]          pc,
    input  logic [16*BP_NUM-1:0] bp_addr,
    input  logic [BP_NUM-1:0]    bp_en,
    input  logic                 resume,
    output logic                 core_reset,
    output logic                 core_run,
    output logic                 done,
    output logic                 timed_out,
    output logic [BP_NUM-1:0]    bp_hit,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instr_cnt
);

    localparam int BUD_W = $clog2(TIMEOUT + 1);

    state_t             state, state_nxt;
    logic [7:0]         rst_cnt, rst_cnt_nxt;
    logic [BUD_W-1:0]   bud_cnt, bud_nxt;
    logic [CNT_W-1:0]   cycle_nxt, instr_nxt;
    logic [BP_NUM-1:0]  bp_hit_nxt;
    logic [BP_NUM-1:0]  hit_arm;
    logic               is_halt;

    assign is_halt = instr_valid && (word_t'(instr) == HALT_OP);

`ifdef LC3_RUN_CTRL_BP_EN
    logic [BP_NUM-1:0] hit_raw;
    logic              mask, mask_nxt;
    word_t             mask_pc, mask_pc_nxt;

    lc3_bp_match #(.BP_NUM(BP_NUM)) u_bp_match (
        .pc      (pc),
        .bp_addr (bp_addr),
        .bp_en   (bp_en),
        .hit     (hit_raw)
    );

    // The core re-fetches the paused pc after resume; suppress that one until pc moves on.
    assign hit_arm = (instr_valid && !(mask && (word_t'(pc) == mask_pc))) ? hit_raw : '0;

    always_comb begin
        mask_nxt    = mask;
        mask_pc_nxt = mask_pc;
        if (state == S_IDLE && start) begin
            mask_nxt = 1'b0;
        end else if (state == S_RUN && bud_cnt != '0) begin
            if (instr_valid && word_t'(pc) != mask_pc)
                mask_nxt = 1'b0;
            if (!is_halt && (|hit_arm)) begin
                mask_nxt    = 1'b1;
                mask_pc_nxt = pc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask    <= 1'b0;
            mask_pc <= '0;
        end else begin
            mask    <= mask_nxt;
            mask_pc <= mask_pc_nxt;
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_en};
    assign hit_arm   = '0;
`endif

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        bud_nxt     = bud_cnt;
        cycle_nxt   = cycle_cnt;
        instr_nxt   = instr_cnt;
        bp_hit_nxt  = bp_hit;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_RST_HOLD;
                    rst_cnt_nxt = 8'(RST_CYCLES - 1);
                    bud_nxt     = BUD_W'(TIMEOUT - 1);
                    cycle_nxt   = '0;
                    instr_nxt   = '0;
                    bp_hit_nxt  = '0;
                end
            end
            S_RST_HOLD: begin
                if (rst_cnt == 8'd0)
                    state_nxt = S_RUN;
                else
                    rst_cnt_nxt = rst_cnt - 8'd1;
            end
            S_RUN: begin
                // Budget expiry freezes the counters and overrides HALT/breakpoints.
                if (bud_cnt == '0) begin
                    state_nxt = S_TIMEOUT;
                end else begin
                    bud_nxt   = bud_cnt - BUD_W'(1);
                    cycle_nxt = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
                    if (instr_valid)
                        instr_nxt = (&instr_cnt) ? instr_cnt : instr_cnt + CNT_W'(1);
                    if (is_halt) begin
                        state_nxt = S_HALTED;
                    end else if (|hit_arm) begin
                        state_nxt  = S_PAUSED;
                        bp_hit_nxt = hit_arm;
                    end
                end
            end
            S_PAUSED: begin
                if (resume) begin
                    state_nxt  = S_RUN;
                    bp_hit_nxt = '0;
                end
            end
            S_HALTED, S_TIMEOUT: begin
                if (!start)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            rst_cnt   <= '0;
            bud_cnt   <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            bp_hit    <= '0;
        end else begin
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            bud_cnt   <= bud_nxt;
            cycle_cnt <= cycle_nxt;
            instr_cnt <= instr_nxt;
            bp_hit    <= bp_hit_nxt;
        end
    end

    assign core_reset = (state == S_IDLE) || (state == S_RST_HOLD);
    assign core_run   = (state == S_RUN);
    assign done       = (state == S_HALTED);
    assign timed_out  = (state == S_TIMEOUT);

endmodule

// File: tb/tb_lc3_run_ctrl.sv
// Directed bench for lc3_run_ctrl: vector table for start/run/HALT, hand sequences for
// budget expiry, counter saturation, reset and (when LC3_RUN_CTRL_BP_EN is defined) breakpoints.
module tb_lc3_run_ctrl;

    localparam logic [15:0] ADD  = 16'h1021;
    localparam logic [15:0] HALT = 16'hF025;

    logic        clock = 1'b0;
    logic        reset, start, instr_valid, resume;
    logic [15:0] instr, pc;
    logic [31:0] bp_addr;
    logic [1:0]  bp_en;

    logic        core_reset, core_run, done, timed_out;
    logic [1:0]  bp_hit;
    logic [31:0] cycle_cnt, instr_cnt;

    logic        s_core_reset, s_core_run, s_done, s_timed_out;
    logic [1:0]  s_bp_hit;
    logic [3:0]  s_cycle_cnt, s_instr_cnt;

    int nvec  = 0;
    int nfail = 0;

    always #5 clock = ~clock;

    lc3_run_ctrl #(.RST_CYCLES(4), .TIMEOUT(100), .CNT_W(32), .BP_NUM(2)) dut (
        .clock(clock), .reset(reset), .start(start), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .resume(resume),
        .core_reset(core_reset), .core_run(core_run), .done(done), .timed_out(timed_out),
        .bp_hit(bp_hit), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    lc3_run_ctrl #(.RST_CYCLES(4), .TIMEOUT(100), .CNT_W(4), .BP_NUM(2)) u_sat (
        .clock(clock), .reset(reset), .start(start), .instr_valid(instr_valid),
        .instr(instr), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .resume(resume),
        .core_reset(s_core_reset), .core_run(s_core_run), .done(s_done), .timed_out(s_timed_out),
        .bp_hit(s_bp_hit), .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt)
    );

    typedef struct {
        logic        st;
        logic        iv;
        logic [15:0] ins;
        logic [15:0] p;
        logic        e_rst;
        logic        e_run;
        logic        e_done;
        logic        e_to;
        logic [31:0] e_cyc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, iv, input logic [15:0] ins, p,
                       input logic e_rst, e_run, e_done, e_to,
                       input logic [31:0] e_cyc, e_ins);
        vec_t v;
        v.st = st; v.iv = iv; v.ins = ins; v.p = p;
        v.e_rst = e_rst; v.e_run = e_run; v.e_done = e_done; v.e_to = e_to;
        v.e_cyc = e_cyc; v.e_ins = e_ins;
        vq.push_back(v);
    endtask

    task automatic step(input logic st, iv, input logic [15:0] ins, p, input logic res);
        start       = st;
        instr_valid = iv;
        instr       = ins;
        pc          = p;
        resume      = res;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_main(input string name, input logic e_rst, e_run, e_done, e_to,
                            input logic [1:0] e_hit, input logic [31:0] e_cyc, e_ins);
        logic [69:0] act, exp;
        act = {core_reset, core_run, done, timed_out, bp_hit, cycle_cnt, instr_cnt};
        exp = {e_rst, e_run, e_done, e_to, e_hit, e_cyc, e_ins};
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got rst=%b run=%b done=%b to=%b hit=%b cyc=%0d ins=%0d, expected rst=%b run=%b done=%b to=%b hit=%b cyc=%0d ins=%0d",
                     name, core_reset, core_run, done, timed_out, bp_hit, cycle_cnt, instr_cnt,
                     e_rst, e_run, e_done, e_to, e_hit, e_cyc, e_ins);
        end
    endtask

    task automatic chk_reset(input string name);
        chk_main(name, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic run_up;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, ADD, 16'h0000, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr_valid = 1'b0; resume = 1'b0;
        instr = '0; pc = '0; bp_addr = '0; bp_en = '0;

        // start/run/HALT table; IDLE edge loads the hold counter, four hold cycles, then RUN
        add(1, 0, ADD,  16'h3000, 1, 0, 0, 0, 0, 0);
        add(1, 1, HALT, 16'h3000, 1, 0, 0, 0, 0, 0);
        add(1, 1, HALT, 16'h3000, 1, 0, 0, 0, 0, 0);
        add(1, 1, ADD,  16'h3000, 1, 0, 0, 0, 0, 0);
        add(1, 0, ADD,  16'h3000, 0, 1, 0, 0, 0, 0);
        add(1, 1, ADD,  16'h3000, 0, 1, 0, 0, 1, 1);
        add(1, 1, ADD,  16'h3001, 0, 1, 0, 0, 2, 2);
        add(1, 0, HALT, 16'h3002, 0, 1, 0, 0, 3, 2);
        for (int k = 0; k < 8; k++)
            add(1, 1, ADD, 16'(16'h3002 + k), 0, 1, 0, 0, 32'(4 + k), 32'(3 + k));
        add(1, 1, HALT, 16'h300A, 0, 0, 1, 0, 12, 11);
        add(1, 0, ADD,  16'h0000, 0, 0, 1, 0, 12, 11);
        add(0, 0, ADD,  16'h0000, 1, 0, 0, 0, 12, 11);
        add(1, 0, ADD,  16'h0000, 1, 0, 0, 0, 0, 0);

        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk_reset("reset_state");
        reset = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].st, vq[i].iv, vq[i].ins, vq[i].p, 1'b0);
            chk_main($sformatf("vec%0d", i), vq[i].e_rst, vq[i].e_run, vq[i].e_done, vq[i].e_to,
                     2'b00, vq[i].e_cyc, vq[i].e_ins);
        end

        // budget expiry: 100 RUN cycles, last one frozen, HALT on that cycle loses
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, ADD, 16'h0000, 1'b0);
        chk_main("hold_last", 1, 0, 0, 0, 2'b00, 0, 0);
        step(1'b1, 1'b0, ADD, 16'h0000, 1'b0);
        chk_main("run_entry", 0, 1, 0, 0, 2'b00, 0, 0);
        for (int k = 1; k <= 99; k++) step(1'b1, 1'b1, ADD, 16'(16'h4000 + k), 1'b0);
        chk_main("pre_timeout", 0, 1, 0, 0, 2'b00, 99, 99);
        step(1'b1, 1'b1, HALT, 16'h4064, 1'b0);
        chk_main("timeout", 0, 0, 0, 1, 2'b00, 99, 99);
        nvec++;
        if ({s_timed_out, s_cycle_cnt, s_instr_cnt} !== {1'b1, 4'hF, 4'hF}) begin
            nfail++;
            $display("FAIL sat_cnt: got to=%b cyc=%0d ins=%0d, expected to=1 cyc=15 ins=15",
                     s_timed_out, s_cycle_cnt, s_instr_cnt);
        end
        step(1'b1, 1'b0, ADD, 16'h0000, 1'b0);
        chk_main("timeout_hold", 0, 0, 0, 1, 2'b00, 99, 99);
        step(1'b0, 1'b0, ADD, 16'h0000, 1'b0);
        chk_main("timeout_clear", 1, 0, 0, 0, 2'b00, 99, 99);

        // reset in the middle of a run
        run_up();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, ADD, 16'(16'h5000 + k), 1'b0);
        chk_main("mid_run", 0, 1, 0, 0, 2'b00, 3, 3);
        reset = 1'b1;
        step(1'b1, 1'b1, ADD, 16'h5003, 1'b0);
        chk_reset("reset_mid_run");
        reset = 1'b0;
        step(1'b0, 1'b0, ADD, 16'h0000, 1'b0);

`ifdef LC3_RUN_CTRL_BP_EN
        bp_addr = {16'h3005, 16'h3001};
        bp_en   = 2'b10;
        run_up();
        chk_main("bp_run_entry", 0, 1, 0, 0, 2'b00, 0, 0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, ADD, 16'(16'h3000 + k), 1'b0);
        chk_main("bp_pre", 0, 1, 0, 0, 2'b00, 5, 5);
        step(1'b1, 1'b1, ADD, 16'h3005, 1'b0);
        chk_main("bp_pause", 0, 0, 0, 0, 2'b10, 6, 6);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, ADD, 16'h3006, 1'b0);
        chk_main("bp_frozen", 0, 0, 0, 0, 2'b10, 6, 6);
        step(1'b1, 1'b0, ADD, 16'h3005, 1'b1);
        chk_main("bp_resume", 0, 1, 0, 0, 2'b00, 6, 6);
        step(1'b1, 1'b1, ADD, 16'h3005, 1'b0);
        chk_main("bp_same_pc", 0, 1, 0, 0, 2'b00, 7, 7);
        step(1'b1, 1'b1, ADD, 16'h3006, 1'b0);
        chk_main("bp_next_pc", 0, 1, 0, 0, 2'b00, 8, 8);
        step(1'b1, 1'b1, ADD, 16'h3005, 1'b0);
        chk_main("bp_rearm", 0, 0, 0, 0, 2'b10, 9, 9);
        reset = 1'b1;
        step(1'b1, 1'b1, ADD, 16'h3006, 1'b0);
        chk_reset("reset_paused");
        reset = 1'b0;
        step(1'b0, 1'b0, ADD, 16'h0000, 1'b0);

        bp_addr = {16'h3002, 16'h3002};
        bp_en   = 2'b11;
        run_up();
        step(1'b1, 1'b1, ADD, 16'h3002, 1'b0);
        chk_main("bp_both", 0, 0, 0, 0, 2'b11, 1, 1);
        step(1'b1, 1'b0, ADD, 16'h3002, 1'b1);
        chk_main("bp_both_resume", 0, 1, 0, 0, 2'b00, 1, 1);
        step(1'b1, 1'b1, ADD, 16'h3003, 1'b0);
        chk_main("bp_move", 0, 1, 0, 0, 2'b00, 2, 2);
        step(1'b1, 1'b1, HALT, 16'h3002, 1'b0);
        chk_main("halt_wins", 0, 0, 1, 0, 2'b00, 3, 3);
        step(1'b0, 1'b0, ADD, 16'h0000, 1'b0);
        chk_main("halt_clear", 1, 0, 0, 0, 2'b00, 3, 3);
`else
        bp_addr = {16'h3005, 16'h3001};
        bp_en   = 2'b11;
        run_up();
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, ADD, 16'(16'h3000 + k), 1'b0);
        chk_main("nobp_run", 0, 1, 0, 0, 2'b00, 6, 6);
        step(1'b1, 1'b0, ADD, 16'h3005, 1'b1);
        chk_main("nobp_resume", 0, 1, 0, 0, 2'b00, 7, 6);
        step(1'b1, 1'b1, HALT, 16'h3001, 1'b0);
        chk_main("nobp_halt", 0, 0, 1, 0, 2'b00, 8, 7);
        reset = 1'b1;
        step(1'b1, 1'b0, ADD, 16'h0000, 1'b0);
        chk_reset("reset_halted");
        reset = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
